block_rx: RTL and testbench
===========================

// Module: block_rx
// PURPOSE
//  Receive end of the two-line symbol link driven by `block` (line0 = O0, line1 = O1).
//  Decodes per-cycle line-pair symbols into framed WIDTH-bit words and presents them on a valid/ready output.
//  Sits in the consumer clock domain. Lines are synchronous to clk; no CDC synchroniser is needed.
// PARAMETERS
//  WIDTH    8   payload bits per frame
//  TIMEOUT  16  consecutive idle symbols inside a frame before abort (>=1)
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  line0      in   1      link line 0 (tx O0)
//  line1      in   1      link line 1 (tx O1)
//  rx_data    out  WIDTH  received word, MSB = first bit on the wire
//  rx_valid   out  1      rx_data holds an unconsumed word
//  rx_ready   in   1      consumer accepts the word on (rx_valid & rx_ready)
//  frame_err  out  1      1-cycle pulse: bad length, extra bits, or timeout
//  overrun    out  1      1-cycle pulse: word completed while rx_valid & !rx_ready; new word dropped
//  busy       out  1      FSM not in IDLE
// BEHAVIOUR
//  Symbols {line1,line0}: 00 IDLE, 01 BIT0, 10 BIT1, 11 DELIM.
//  Input stage: lines registered once. The FSM acts on the registered symbol.
//  Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, counters=0.
//  Reset applied mid-frame discards the partial frame and any held word.
//  IDLE: DELIM -> SHIFT with bitcnt=0 and idlecnt=0. All other symbols are ignored.
//  SHIFT:
//   - BITx with bitcnt<WIDTH: shreg={shreg[WIDTH-2:0],x}; bitcnt++; idlecnt=0.
//   - BITx with bitcnt==WIDTH: frame_err pulse; go to IDLE.
//   - IDLE: idlecnt++. When idlecnt reaches TIMEOUT: frame_err pulse; go to IDLE.
//   - DELIM with bitcnt==WIDTH: frame completes. If !rx_valid or (rx_valid & rx_ready) the same cycle,
//     load rx_data=shreg and set rx_valid=1. Otherwise pulse overrun and leave rx_data unchanged.
//     In both cases go to IDLE.
//   - DELIM with bitcnt!=WIDTH (including 0): frame_err pulse; stay in SHIFT; bitcnt=0 (re-sync as a start).
//  Latency: rx_valid rises on the 2nd posedge after the closing DELIM appears on the lines.
//  Output handshake: rx_valid holds until a cycle with rx_ready=1, then clears next edge unless reloaded.
//   rx_data is stable while rx_valid=1. rx_ready while !rx_valid has no effect.
//  Back-to-back: DELIM|bits|DELIM|DELIM|bits|DELIM is legal. The closing DELIM returns to IDLE;
//   the next DELIM opens a new frame. Minimum frame period = WIDTH+2 cycles.
//  Counter widths: bitcnt = $clog2(WIDTH+1); idlecnt = $clog2(TIMEOUT+1). No counter wraps (saturation is
//   unreachable because of the aborts above).
//  frame_err and overrun are never both asserted in the same cycle.
// STRUCTURE
//  block_pkg: symbol localparams SYM_IDLE/SYM_BIT0/SYM_BIT1/SYM_DELIM and the state enum {IDLE, SHIFT}.
//   Shared with the tx side.
//  Sub-module block_rx_sym: input register plus 2-bit symbol decode (is_bit, bit_val, is_delim, is_idle).
//  Top level: FSM, shift register, both counters, output holding register.
// TESTING (WIDTH=8, TIMEOUT=16)
//  1. DELIM, bits 1,0,1,0,0,1,0,1, DELIM, rx_ready=1 -> rx_data=8'hA5, rx_valid for 1 cycle, no error.
//  2. Same frame with rx_ready=0 for 10 cycles -> rx_valid and rx_data=8'hA5 held; clears 1 cycle after ready.
//  3. Second frame 8'h3C completes while 8'hA5 is held -> overrun pulse; rx_data stays 8'hA5.
//  4. DELIM, 5 bits, DELIM, then 8 bits of 8'hFF, DELIM -> frame_err once, then rx_data=8'hFF.
//  5. DELIM, 3 bits, 16 IDLE -> frame_err on the 16th idle, busy=0. 15 IDLE then bits -> no error.
//  6. rst pulsed after 4 bits of a frame -> all outputs 0. A following complete frame decodes correctly.

Source files
------------

// File: rtl/block_pkg.sv
// Shared definitions for the two-line symbol link (used by both tx and rx sides).
package block_pkg;

  // Line-pair symbols, encoded as {line1, line0}
  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_BIT0  = 2'b01;
  localparam logic [1:0] SYM_BIT1  = 2'b10;
  localparam logic [1:0] SYM_DELIM = 2'b11;

  // Receiver framing state
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/block_rx_sym.sv
// Input stage of the receiver: registers the two link lines once and decodes
// the registered symbol into one-hot style flags for the framing FSM.
module block_rx_sym
  import block_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line0,
  input  logic i_line1,
  output logic o_is_idle,
  output logic o_is_bit,
  output logic o_bit_val,
  output logic o_is_delim
);

  logic [1:0] r_sym;

  // Register the line pair; reset value is the IDLE symbol so nothing is decoded after reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sym <= SYM_IDLE;
    end else begin
      r_sym <= {i_line1, i_line0};
    end
  end

  // Decode the registered symbol
  always_comb begin
    o_is_idle  = (r_sym == SYM_IDLE);
    o_is_bit   = (r_sym == SYM_BIT0) || (r_sym == SYM_BIT1);
    o_bit_val  = (r_sym == SYM_BIT1);
    o_is_delim = (r_sym == SYM_DELIM);
  end

endmodule

// File: rtl/block_rx.sv
// Receive end of the two-line symbol link: frames DELIM-delimited bit runs into
// WIDTH-bit words and presents them on a valid/ready output.
//
// Output handshake: rx_valid/rx_data hold a word until a cycle where
// rx_valid & rx_ready is seen at a posedge; that edge consumes the word.
// rx_data never changes while rx_valid is high except by reload in the very
// cycle the held word is consumed. A completed frame that finds the holding
// register occupied and not being consumed is dropped with an overrun pulse.
module block_rx
  import block_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             line0,
  input  logic             line1,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BITS_FULL = BW'(WIDTH);
  // The idle symbol that makes the run reach TIMEOUT arrives while the count is TIMEOUT-1
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  // Decoded symbol from the input stage
  logic w_is_idle;
  logic w_is_bit;
  logic w_bit_val;
  logic w_is_delim;

  block_rx_sym u_sym (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_line0    (line0),
    .i_line1    (line1),
    .o_is_idle  (w_is_idle),
    .o_is_bit   (w_is_bit),
    .o_bit_val  (w_bit_val),
    .o_is_delim (w_is_delim)
  );

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bitcnt;
  logic [IW-1:0]    r_idlecnt;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_overrun;

  logic w_full;
  logic w_idle_last;
  logic w_shift;
  logic w_cnt_clr;
  logic w_idle_inc;
  logic w_err;
  logic w_done;
  logic w_load;
  logic w_ovr;

  assign w_full      = (r_bitcnt == BITS_FULL);
  assign w_idle_last = (r_idlecnt == IDLE_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: a DELIM opens a frame; overlong, timed-out or completed frames return to IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_is_delim) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (w_is_bit && w_full)               w_next_state = IDLE;
        else if (w_is_idle && w_idle_last)    w_next_state = IDLE;
        else if (w_is_delim && w_full)        w_next_state = IDLE;
        else                                  w_next_state = SHIFT;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // FSM outputs: datapath controls and event strobes for the current symbol
  always_comb begin
    w_shift    = 1'b0;
    w_cnt_clr  = 1'b0;
    w_idle_inc = 1'b0;
    w_err      = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_clr = w_is_delim;
      end
      SHIFT: begin
        if (w_is_bit) begin
          if (w_full) w_err   = 1'b1;
          else        w_shift = 1'b1;
        end else if (w_is_idle) begin
          if (w_idle_last) w_err      = 1'b1;
          else             w_idle_inc = 1'b1;
        end else begin
          // DELIM: closes a full frame, otherwise restarts the frame as a fresh start
          if (w_full) begin
            w_done = 1'b1;
          end else begin
            w_err     = 1'b1;
            w_cnt_clr = 1'b1;
          end
        end
      end
      default: ;
    endcase
    w_load = w_done && (!r_rx_valid || rx_ready);
    w_ovr  = w_done && r_rx_valid && !rx_ready;
  end

  // Shift register and bit/idle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_idlecnt <= '0;
    end else if (w_cnt_clr) begin
      r_bitcnt  <= '0;
      r_idlecnt <= '0;
    end else if (w_shift) begin
      r_shreg   <= {r_shreg[WIDTH-2:0], w_bit_val};
      r_bitcnt  <= r_bitcnt + 1'b1;
      r_idlecnt <= '0;
    end else if (w_idle_inc) begin
      r_idlecnt <= r_idlecnt + 1'b1;
    end
  end

  // Output holding register and single-cycle event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        r_rx_data  <= r_shreg;
        r_rx_valid <= 1'b1;
      end else if (rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      r_frame_err <= w_err;
      r_overrun   <= w_ovr;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_block_rx.sv
// Testbench for block_rx: directed scenarios plus randomized symbol streams,
// checked by a scoreboard fed from a frame-level reference model.
module tb_block_rx;
  import block_pkg::*;

  localparam int W  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         line0 = 1'b0;
  logic         line1 = 1'b0;
  logic         rx_ready = 1'b0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  block_rx #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .line0     (line0),
    .line1     (line1),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];   // words expected on the output, in order
  int           err_q[$];   // cycle stamps of expected frame_err pulses
  int           ovr_q[$];   // cycle stamps of expected overrun pulses

  // ---------------- reference model ----------------
  // Frame-level view: a frame is open after a DELIM, collects bits in a queue,
  // and is judged by the number of collected bits when something else arrives.
  bit         m_in_frame = 0;
  bit         m_held     = 0;
  bit         m_bits[$];
  int         m_idle_run = 0;
  logic [1:0] prev_sym   = SYM_IDLE;
  logic       rdy        = 1'b0;
  bit         rand_rdy   = 0;

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w = '0;
    foreach (m_bits[i]) w = (w << 1) | W'(m_bits[i]);
    return w;
  endfunction

  // Symbol p is the one seen by the receiver at the coming edge; r is rx_ready at that edge
  function automatic void model_step(logic [1:0] p, logic r, int stamp);
    bit loaded = 0;
    if (!m_in_frame) begin
      if (p == SYM_DELIM) begin
        m_in_frame = 1;
        m_bits.delete();
        m_idle_run = 0;
      end
    end else begin
      case (p)
        SYM_BIT0, SYM_BIT1: begin
          if (m_bits.size() == W) begin
            err_q.push_back(stamp);
            m_in_frame = 0;
          end else begin
            m_bits.push_back(p == SYM_BIT1);
            m_idle_run = 0;
          end
        end
        SYM_IDLE: begin
          m_idle_run++;
          if (m_idle_run == TO) begin
            err_q.push_back(stamp);
            m_in_frame = 0;
          end
        end
        default: begin
          if (m_bits.size() == W) begin
            m_in_frame = 0;
            if (!m_held || r) begin
              exp_q.push_back(pack_bits());
              m_held = 1;
              loaded = 1;
            end else begin
              ovr_q.push_back(stamp);
            end
          end else begin
            err_q.push_back(stamp);
            m_bits.delete();
            m_idle_run = 0;
          end
        end
      endcase
    end
    if (!loaded && r) m_held = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(logic [1:0] s);
    @(posedge clk);
    #1;
    if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
    rst = 1'b0;
    {line1, line0} = s;
    rx_ready = rdy;
    model_step(prev_sym, rdy, cyc + 1);
    prev_sym = s;
  endtask

  task automatic reset_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      {line1, line0} = SYM_IDLE;
      rx_ready = rdy;
    end
    m_in_frame = 0;
    m_held     = 0;
    m_bits.delete();
    m_idle_run = 0;
    exp_q.delete();
    err_q.delete();
    ovr_q.delete();
    prev_sym = SYM_IDLE;
  endtask

  task automatic idles(int n);
    for (int i = 0; i < n; i++) step(SYM_IDLE);
  endtask

  // First n bits of w, MSB first
  task automatic send_bits(logic [W-1:0] w, int n);
    for (int i = 0; i < n; i++) step(w[W-1-i] ? SYM_BIT1 : SYM_BIT0);
  endtask

  task automatic send_frame(logic [W-1:0] w);
    step(SYM_DELIM);
    send_bits(w, W);
    step(SYM_DELIM);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] w;
    int           s;
    if (!rst) begin
      if (rx_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_valid_unexpected: got data %0h expected no word (cycle %0d)", rx_data, cyc);
        end else if (rx_data !== exp_q[0]) begin
          errors++;
          $display("FAIL rx_data_held: got %0h expected %0h (cycle %0d)", rx_data, exp_q[0], cyc);
        end
        if (rx_ready && exp_q.size() != 0) w = exp_q.pop_front();
      end
      if (frame_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL frame_err_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else begin
          s = err_q.pop_front();
          if (s != cyc) begin
            errors++;
            $display("FAIL frame_err_timing: got cycle %0d expected cycle %0d", cyc, s);
          end
        end
      end
      if (overrun) begin
        checks++;
        if (ovr_q.size() == 0) begin
          errors++;
          $display("FAIL overrun_unexpected: got pulse expected none (cycle %0d)", cyc);
        end else begin
          s = ovr_q.pop_front();
          if (s != cyc) begin
            errors++;
            $display("FAIL overrun_timing: got cycle %0d expected cycle %0d", cyc, s);
          end
        end
      end
      if (frame_err && overrun) begin
        checks++;
        errors++;
        $display("FAIL err_ovr_exclusive: got both pulses expected at most one (cycle %0d)", cyc);
      end
      // Expected pulses whose cycle has passed without being seen
      if (err_q.size() != 0 && err_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL frame_err_missing: got no pulse expected at cycle %0d", err_q.pop_front());
      end
      if (ovr_q.size() != 0 && ovr_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL overrun_missing: got no pulse expected at cycle %0d", ovr_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rdy = 1'b0;
    reset_cycles(3);
    step(SYM_IDLE);
    @(negedge clk);
    check("reset_rx_data",   32'(rx_data),   32'h0);
    check("reset_rx_valid",  32'(rx_valid),  32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun",   32'(overrun),   32'h0);
    check("reset_busy",      32'(busy),      32'h0);

    // 1: basic frame, consumer always ready
    rdy = 1'b1;
    send_frame(8'hA5);
    idles(3);

    // 2: consumer stalls; word must be held
    rdy = 1'b0;
    send_frame(8'hA5);
    idles(10);
    @(negedge clk);
    check("stall_rx_valid", 32'(rx_valid), 32'h1);
    check("stall_rx_data",  32'(rx_data),  32'hA5);

    // 3: second frame completes while the first is still held
    send_frame(8'h3C);
    idles(3);
    @(negedge clk);
    check("overrun_keeps_data", 32'(rx_data), 32'hA5);
    rdy = 1'b1;
    idles(3);
    @(negedge clk);
    check("released_rx_valid", 32'(rx_valid), 32'h0);

    // 4: short frame re-synchronised by its DELIM, then a good frame
    step(SYM_DELIM);
    send_bits(8'hB0, 5);
    step(SYM_DELIM);
    send_bits(8'hFF, W);
    step(SYM_DELIM);
    idles(3);

    // 5: timeout after 16 idles, then 15 idles inside a frame is tolerated
    step(SYM_DELIM);
    send_bits(8'hE0, 3);
    idles(TO);
    idles(2);
    @(negedge clk);
    check("timeout_busy", 32'(busy), 32'h0);
    step(SYM_DELIM);
    send_bits(8'h60, 3);
    idles(TO - 1);
    send_bits(8'h68 << 3, 5);
    step(SYM_DELIM);
    idles(3);

    // 6: reset in the middle of a frame, with a word held
    rdy = 1'b0;
    send_frame(8'h99);
    step(SYM_DELIM);
    send_bits(8'hF0, 4);
    reset_cycles(1);
    step(SYM_IDLE);
    @(negedge clk);
    check("midreset_rx_data",  32'(rx_data),  32'h0);
    check("midreset_rx_valid", 32'(rx_valid), 32'h0);
    check("midreset_busy",     32'(busy),     32'h0);
    rdy = 1'b1;
    send_frame(8'h5A);
    idles(3);

    // Extra bit beyond WIDTH, then the stray DELIM opens a frame that times out
    step(SYM_DELIM);
    send_bits(8'hC3, W);
    step(SYM_BIT1);
    step(SYM_DELIM);
    idles(TO + 2);

    // Back-to-back frames at minimum period
    send_frame(8'h12);
    send_frame(8'hED);
    send_frame(8'h00);
    idles(3);

    // Randomized traffic with a randomly stalling consumer
    rand_rdy = 1;
    for (int it = 0; it < 300; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        send_frame(W'($urandom));
      end else if (kind == 6) begin
        step(SYM_DELIM);
        send_bits(W'($urandom), $urandom_range(0, W - 1));
        step(SYM_DELIM);
      end else if (kind == 7) begin
        idles($urandom_range(0, TO + 4));
      end else begin
        for (int k = 0; k < 4; k++) step(2'($urandom_range(0, 3)));
      end
    end

    // Drain: consumer ready, long idle so any open frame times out
    rand_rdy = 0;
    rdy = 1'b1;
    idles(TO + 8);
    @(negedge clk);
    check("drain_words", 32'(exp_q.size()), 32'h0);
    check("drain_errs",  32'(err_q.size()), 32'h0);
    check("drain_ovrs",  32'(ovr_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
